ram_bus_master: RTL and testbench
=================================

// Module: ram_bus_master
// PURPOSE
//  Initiator for the 32x8 shared-bus RAM: the bus has an inout data line, rd_wr, a 2-bit select s, and a RAM-driven en.
//  Converts single-cycle client requests into properly sequenced select/direction/data phases.
//  Owns turnaround, so the master and the RAM never drive Io together.
//  Sits between the datapath/controller and the RAM in the top level.
// PARAMETERS
//  ADDR_W      5      address width (32 locations)
//  DATA_W      8      data width
//  ACCESS_CYC  2      cycles s is held at SEL per access (>=1)
//  SEL         2'b00  select code that enables the RAM
//  DESEL       2'b11  select code that idles the RAM
// PORTS
//  clk     in     1       single clock, rising edge
//  rst     in     1       asynchronous, active-high reset
//  req     in     1       client request; sampled only when busy=0
//  we      in     1       1=write, 0=read; captured with req
//  addr    in     ADDR_W  start address; captured with req
//  wdata   in     DATA_W  write data; captured with req
//  busy    out    1       transaction in progress
//  rdata   out    DATA_W  read data; valid when rvalid=1, held until the next read
//  rvalid  out    1       one-cycle pulse per read beat
//  done    out    1       one-cycle pulse at transaction end
//  Io      inout  DATA_W  shared data bus; master drives only while drv_q=1
//  rd_wr   out    1       1=read, 0=write
//  s       out    2       RAM select
//  ram_en  in     1       RAM's en output (1 = RAM driving Io)
// BEHAVIOUR
//  - Reset: state=IDLE, busy=0, rvalid=0, done=0, rdata=0, s=DESEL, rd_wr=1, Io released (Z).
//    Reset mid-transaction releases Io and deselects immediately. No partial beat completes.
//  - FSM: IDLE -> SETUP -> ACCESS -> RELEASE -> IDLE.
//  - IDLE: s=DESEL, rd_wr=1, Io=Z. When req=1, capture we/addr/wdata, set busy=1, go to SETUP.
//  - SETUP (1 cycle): address and rd_wr=!we driven; s=DESEL; write data is driven on Io only if we=1.
//  - ACCESS (ACCESS_CYC cycles): s=SEL; address, rd_wr and data held stable.
//    Read: Io=Z; rdata<=Io on the last ACCESS cycle; rvalid pulses the next cycle.
//    Read with ram_en=0 on that last cycle: rdata<=8'h00 and rvalid still pulses.
//  - RELEASE (1 cycle): s=DESEL. For a write, Io stays driven this cycle so data is stable past deselect,
//    then goes Z. done pulses; busy=0 the next cycle.
//  - Invariants: Io is never driven by the master while rd_wr=1.
//    Address and rd_wr never change while s=SEL.
//  - req while busy=1 is ignored, not queued. Minimum back-to-back spacing: 3+ACCESS_CYC cycles.
//  - A req in the same cycle as done (busy still 1) is ignored.
//  - Address width is exact. No arithmetic except as in CONFIGURATION.
// CONFIGURATION
//  RAM_MASTER_BURST_EN defined:
//    - Adds input len[ADDR_W-1:0], captured with req. Beats = len+1.
//    - After each beat's ACCESS, go RELEASE -> SETUP with addr+1, wrapping 31->0.
//    - Write bursts reuse wdata sampled at each SETUP; the client holds wdata per beat and observes
//      beat_ack (1-cycle pulse at each SETUP, output added).
//    - done pulses only after the last beat.
//  Undefined: single-beat only; len and beat_ack do not exist.
// STRUCTURE
//  - Shared package ram_bus_pkg: state encoding (IDLE/SETUP/ACCESS/RELEASE), SEL/DESEL codes,
//    ADDR_W/DATA_W defaults. The RAM and this master share the package.
//  - Sub-module ram_bus_io_pad: tri-state driver (Io = drv ? dout : 'bz; din = Io).
//  - FSM, access counter and capture registers live in the top.
// TESTING (bench contains behavioural RAM model on the same Io net)
//  1. Write: req, we=1, addr=5'd3, wdata=8'hA5. Expect SETUP, then s=00 for 2 cycles, then done,
//     and RAM[3]=8'hA5. No bus contention (no X on Io).
//  2. Read back: req, we=0, addr=5'd3. Expect rvalid with rdata=8'hA5; done next to it; Io Z from master throughout.
//  3. Reset asserted during ACCESS of a write to addr 7. Expect s=11 and Io=Z within the same cycle;
//     busy=0 and rvalid=0 after reset.
//  4. req pulsed while busy, addr=9. Expect no second transaction; RAM[9] unchanged; exactly one done.
//  5. Addresses 0 and 31, data 8'h00/8'hFF. Expect exact readback and no aliasing into neighbours.
//  6. (BURST_EN) Write len=2 from addr=30 with data 11,22,33. Expect RAM[30]=11, RAM[31]=22, RAM[0]=33,
//     three beat_ack pulses, one done.

Source files
------------

// File: rtl/ram_bus_pkg.sv
// Shared definitions for the 32x8 shared-bus RAM and its bus master:
// transaction state encoding, select codes and default bus widths.
package ram_bus_pkg;

  localparam int RAM_ADDR_W = 5;
  localparam int RAM_DATA_W = 8;

  localparam logic [1:0] SEL_CODE   = 2'b00;
  localparam logic [1:0] DESEL_CODE = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SETUP   = 2'b01,
    ACCESS  = 2'b10,
    RELEASE = 2'b11
  } bus_state_t;

endpackage

// File: rtl/ram_bus_io_pad.sv
// Tri-state driver for the shared Io data line; din always reflects the
// resolved bus value, whoever is driving it.
module ram_bus_io_pad #(
  parameter int W = 8
) (
  input  logic         drv,
  input  logic [W-1:0] dout,
  output logic [W-1:0] din,
  inout  wire  [W-1:0] io
);

  assign io  = drv ? dout : {W{1'bz}};
  assign din = io;

endmodule

// File: rtl/ram_bus_master.sv
// Bus master for the shared-bus RAM: sequences select, direction and data
// phases (IDLE -> SETUP -> ACCESS -> RELEASE) and owns the Io turnaround.
// Optional multi-beat bursts with address wrap: define RAM_MASTER_BURST_EN.
module ram_bus_master
  import ram_bus_pkg::*;
#(
  parameter int         ADDR_W     = RAM_ADDR_W,
  parameter int         DATA_W     = RAM_DATA_W,
  parameter int         ACCESS_CYC = 2,
  parameter logic [1:0] SEL        = SEL_CODE,
  parameter logic [1:0] DESEL      = DESEL_CODE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
`ifdef RAM_MASTER_BURST_EN
  input  logic [ADDR_W-1:0] len,
  output logic              beat_ack,
`endif
  output logic              busy,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              done,
  inout  wire  [DATA_W-1:0] Io,
  output logic              rd_wr,
  output logic [1:0]        s,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic              ram_en
);

  localparam int CNT_W = (ACCESS_CYC > 1) ? $clog2(ACCESS_CYC) : 1;

  bus_state_t        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] dout_q;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] rdata_q;
  logic              busy_q, rvalid_q, done_q, rd_wr_q, drv_q;
  logic [1:0]        s_q;
`ifdef RAM_MASTER_BURST_EN
  logic [ADDR_W-1:0] beats_q;
  logic              beat_ack_q;
`endif

  ram_bus_io_pad #(.W(DATA_W)) u_pad (
    .drv  (drv_q),
    .dout (dout_q),
    .din  (din),
    .io   (Io)
  );

  // drv_q only ever rises together with rd_wr_q falling, so the master
  // never drives Io while the RAM may be answering a read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      dout_q   <= '0;
      rdata_q  <= '0;
      busy_q   <= 1'b0;
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
      rd_wr_q  <= 1'b1;
      drv_q    <= 1'b0;
      s_q      <= DESEL;
`ifdef RAM_MASTER_BURST_EN
      beats_q    <= '0;
      beat_ack_q <= 1'b0;
`endif
    end else begin
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
`ifdef RAM_MASTER_BURST_EN
      beat_ack_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (req) begin
            state_q <= SETUP;
            busy_q  <= 1'b1;
            we_q    <= we;
            addr_q  <= addr;
            dout_q  <= wdata;
            rd_wr_q <= ~we;
            drv_q   <= we;
`ifdef RAM_MASTER_BURST_EN
            beats_q    <= len;
            beat_ack_q <= 1'b1;
`endif
          end
        end
        SETUP: begin
          state_q <= ACCESS;
          s_q     <= SEL;
          cnt_q   <= CNT_W'(ACCESS_CYC - 1);
        end
        ACCESS: begin
          if (cnt_q == '0) begin
            state_q <= RELEASE;
            s_q     <= DESEL;
            if (!we_q) begin
              rdata_q  <= ram_en ? din : '0;
              rvalid_q <= 1'b1;
            end
`ifdef RAM_MASTER_BURST_EN
            done_q <= (beats_q == '0);
`else
            done_q <= 1'b1;
`endif
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RELEASE: begin
`ifdef RAM_MASTER_BURST_EN
          if (beats_q != '0) begin
            state_q    <= SETUP;
            beats_q    <= beats_q - ADDR_W'(1);
            addr_q     <= addr_q + ADDR_W'(1);
            dout_q     <= wdata;
            beat_ack_q <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            drv_q   <= 1'b0;
            rd_wr_q <= 1'b1;
          end
`else
          state_q <= IDLE;
          busy_q  <= 1'b0;
          drv_q   <= 1'b0;
          rd_wr_q <= 1'b1;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign rdata    = rdata_q;
  assign rvalid   = rvalid_q;
  assign done     = done_q;
  assign rd_wr    = rd_wr_q;
  assign s        = s_q;
  assign ram_addr = addr_q;
`ifdef RAM_MASTER_BURST_EN
  assign beat_ack = beat_ack_q;
`endif

endmodule

// File: tb/tb_ram_bus_master.sv
// Bench for ram_bus_master: behavioural 32x8 RAM on the shared Io net, a
// transaction-level reference memory, table vectors, corner sequences, random traffic.
module tb_ram_bus_master;

  localparam int AC = 2;

  logic       clk, rst, req, we;
  logic [4:0] addr;
  logic [7:0] wdata;
  logic       busy, rvalid, done, rd_wr;
  logic [7:0] rdata;
  logic [1:0] s;
  logic [4:0] ram_addr;
  wire  [7:0] Io;
  wire        ram_en;
`ifdef RAM_MASTER_BURST_EN
  logic [4:0] len;
  logic       beat_ack;
`endif

  ram_bus_master #(.ACCESS_CYC(AC)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
`ifdef RAM_MASTER_BURST_EN
    .len      (len),
    .beat_ack (beat_ack),
`endif
    .busy     (busy),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .done     (done),
    .Io       (Io),
    .rd_wr    (rd_wr),
    .s        (s),
    .ram_addr (ram_addr),
    .ram_en   (ram_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: drives Io on selected reads, stores Io on selected writes.
  logic [7:0] mem [32] = '{default: 8'h5C};
  assign ram_en = (s == 2'b00) && rd_wr;
  assign Io     = ram_en ? mem[ram_addr] : 8'bz;
  always @(posedge clk) if (s == 2'b00 && !rd_wr) mem[ram_addr] <= Io;

  logic [7:0] ref_mem [32] = '{default: 8'h5C};

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Issue one request at the current negedge and observe a fixed 10-cycle window.
  task automatic run_txn(input logic t_we, input logic [4:0] t_addr, input logic [7:0] t_wdata,
                         input int extra_at, output logic [7:0] got, output int n_rv,
                         output int n_done, output int n_busy, output int n_sel,
                         output int done_c, output logic ok);
    got = rdata; n_rv = 0; n_done = 0; n_busy = 0; n_sel = 0; done_c = -1; ok = 1'b1;
    req = 1'b1; we = t_we; addr = t_addr; wdata = t_wdata;
    @(negedge clk);
    for (int c = 1; c <= 10; c++) begin
      if (busy) n_busy++;
      if (s == 2'b00) begin
        n_sel++;
        if (ram_addr !== t_addr || rd_wr !== ~t_we || (t_we && Io !== t_wdata)) ok = 1'b0;
      end
      if (done) begin n_done++; done_c = c; end
      if (rvalid) begin n_rv++; got = rdata; end
      if (c == extra_at) begin
        req = 1'b1; we = 1'b1; addr = 5'd9; wdata = 8'hEE;
      end else begin
        req = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_txn(input logic t_we, input logic [4:0] t_addr, input logic [7:0] t_wdata,
                           input logic [7:0] exp_rd, input int extra_at);
    logic [7:0] prev, got;
    int n_rv, n_done, n_busy, n_sel, done_c;
    logic ok;
    prev = rdata;
    run_txn(t_we, t_addr, t_wdata, extra_at, got, n_rv, n_done, n_busy, n_sel, done_c, ok);
    chk("done_latency", done_c, 2 + AC);
    chk("done_count", n_done, 1);
    chk("sel_cycles", n_sel, AC);
    chk("busy_cycles", n_busy, 2 + AC);
    chk("bus_stable_while_sel", {31'd0, ok}, 1);
    chk("rvalid_count", n_rv, t_we ? 0 : 1);
    if (t_we) begin
      ref_mem[t_addr] = t_wdata;
      chk("rdata_hold", rdata, prev);
      chk("ram_written", mem[t_addr], t_wdata);
    end else begin
      chk("rdata", got, exp_rd);
    end
  endtask

  typedef struct packed {
    logic       we;
    logic [4:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t tbl [10];

  initial begin
    tbl[0] = '{1'b1, 5'd3,  8'hA5, 8'h00};
    tbl[1] = '{1'b0, 5'd3,  8'h00, 8'hA5};
    tbl[2] = '{1'b1, 5'd0,  8'h00, 8'h00};
    tbl[3] = '{1'b1, 5'd31, 8'hFF, 8'h00};
    tbl[4] = '{1'b1, 5'd1,  8'h5A, 8'h00};
    tbl[5] = '{1'b1, 5'd30, 8'hC3, 8'h00};
    tbl[6] = '{1'b0, 5'd0,  8'h00, 8'h00};
    tbl[7] = '{1'b0, 5'd31, 8'h00, 8'hFF};
    tbl[8] = '{1'b0, 5'd1,  8'h00, 8'h5A};
    tbl[9] = '{1'b0, 5'd30, 8'h00, 8'hC3};

    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
`ifdef RAM_MASTER_BURST_EN
    len = '0;
`endif
    #3;
    chk("reset_s", {30'd0, s}, 2'b11);
    chk("reset_rd_wr", {31'd0, rd_wr}, 1);
    chk("reset_busy", {31'd0, busy}, 0);
    chk("reset_rvalid", {31'd0, rvalid}, 0);
    chk("reset_done", {31'd0, done}, 0);
    chk("reset_rdata", {24'd0, rdata}, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++)
      check_txn(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rd, -1);
    chk("no_alias_addr2", mem[2], 8'h5C);
    chk("no_alias_addr29", mem[29], 8'h5C);

    // Reset during the first ACCESS cycle of a write to address 7.
    req = 1'b1; we = 1'b1; addr = 5'd7; wdata = 8'h77;
    @(negedge clk); req = 1'b0;
    @(negedge clk);
    chk("rst_mid_pre_sel", {30'd0, s}, 2'b00);
    rst = 1'b1;
    #1;
    chk("rst_mid_s", {30'd0, s}, 2'b11);
    chk("rst_mid_rd_wr", {31'd0, rd_wr}, 1);
    chk("rst_mid_busy", {31'd0, busy}, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_rvalid", {31'd0, rvalid}, 0);
    chk("rst_mid_done", {31'd0, done}, 0);
    @(negedge clk); @(negedge clk);
    chk("rst_mid_no_partial", mem[7], ref_mem[7]);

    // Requests while busy (mid-ACCESS, and coincident with done) are dropped.
    check_txn(1'b1, 5'd2, 8'h42, 8'h00, 2);
    chk("busy_req_ignored", mem[9], ref_mem[9]);
    check_txn(1'b0, 5'd2, 8'h00, 8'h42, 4);
    chk("done_req_ignored", mem[9], ref_mem[9]);

    for (int i = 0; i < 40; i++) begin
      logic       r_we;
      logic [4:0] r_addr;
      logic [7:0] r_data;
      r_we   = 1'($urandom_range(0, 1));
      r_addr = 5'($urandom_range(0, 31));
      r_data = 8'($urandom_range(0, 255));
      check_txn(r_we, r_addr, r_data, ref_mem[r_addr], -1);
    end
    for (int a = 0; a < 32; a++) chk("ram_image", mem[a], ref_mem[a]);

`ifdef RAM_MASTER_BURST_EN
    begin
      logic [7:0] bd [3];
      int idx, n_ack, n_dn;
      bd[0] = 8'h11; bd[1] = 8'h22; bd[2] = 8'h33;
      idx = 0; n_ack = 0; n_dn = 0;
      len = 5'd2; req = 1'b1; we = 1'b1; addr = 5'd30; wdata = bd[0];
      @(negedge clk);
      req = 1'b0;
      for (int c = 0; c < 30; c++) begin
        if (beat_ack) begin
          n_ack++;
          idx++;
          if (idx < 3) wdata = bd[idx];
        end
        if (done) n_dn++;
        @(negedge clk);
      end
      len = '0;
      ref_mem[30] = 8'h11; ref_mem[31] = 8'h22; ref_mem[0] = 8'h33;
      chk("burst_ram30", mem[30], 8'h11);
      chk("burst_ram31", mem[31], 8'h22);
      chk("burst_ram0", mem[0], 8'h33);
      chk("burst_beat_acks", n_ack, 3);
      chk("burst_done_count", n_dn, 1);
      chk("burst_ram1_untouched", mem[1], ref_mem[1]);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
